hex2ascii_stream: RTL and testbench
===================================

Name: hex2ascii_stream

Overview:
- Parametrised hex-to-ASCII serialiser with full valid/ready handshakes on both sides.
- Accepts one NUM_DIGITS-nibble word and emits its hex characters MSB-nibble first, one byte per beat.
- Optional leading-zero suppression, upper/lower-case selection and a configurable terminator.
- Sits between debug/register-dump sources and the UART TX byte path; back-pressure from the TX path is honoured.

Parameters:
- NUM_DIGITS, 4, number of hex nibbles per input word (1..16); input width is NUM_DIGITS*4.
- TERM_MODE, 2, terminator after the last digit: 0 = none, 1 = space (0x20), 2 = CR LF (0x0D 0x0A).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- hex_valid_i  in  1  input word valid.
- hex_ready_o  out  1  block can accept a word.
- hex_data_i  in  NUM_DIGITS*4  word to convert, MSB nibble printed first.
- lower_i  in  1  1 = a-f, 0 = A-F; sampled at accept.
- lzs_i  in  1  1 = suppress leading zero nibbles; sampled at accept.
- busy_o  out  1  high from accept until the final character handshake.
- ascii_valid_o  out  1  output byte valid.
- ascii_ready_i  in  1  downstream accepts byte.
- ascii_data_o  out  8  ASCII character.
- ascii_last_o  out  1  marks the final byte of the frame (terminator, or last digit if TERM_MODE=0).

Behaviour:
- Reset (asynchronous, rst_ni low): state IDLE, hex_ready_o=1, busy_o=0, ascii_valid_o=0, ascii_data_o=0x00, ascii_last_o=0, counters and word register cleared. Reset asserted mid-frame aborts the frame; no further bytes are emitted.
- Accept: a word is taken on a cycle with hex_valid_i & hex_ready_o. The word, lower_i and lzs_i are latched. hex_ready_o is high only in IDLE.
- Latency: the first byte is presented with ascii_valid_o=1 on the cycle after accept.
- Output handshake: a byte completes on ascii_valid_o & ascii_ready_i. While ascii_ready_i is low, ascii_data_o, ascii_last_o and ascii_valid_o are held stable. Throughput is one byte per cycle with ascii_ready_i held high.
- FSM states: IDLE -> [PREFIX0 -> PREFIX1, only with the macro enabled] -> DIGIT -> TERM0 -> TERM1 -> IDLE.
  - DIGIT repeats until the digit counter reaches NUM_DIGITS-1.
  - TERM0 is skipped when TERM_MODE=0.
  - TERM1 is visited only when TERM_MODE=2.
  - Transitions occur only on an output handshake.
- Digit counter:
  - Width is the minimum bits to hold NUM_DIGITS-1, with 1 bit minimum.
  - Without lzs_i, it starts at 0.
  - With lzs_i, it starts at the index of the first nonzero nibble, found by a priority encoder at accept. An all-zero word starts at NUM_DIGITS-1, so "0" is always emitted.
- Nibble mapping: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (lower_i=0) or 0x61-0x66 (lower_i=1).
- Frame end: after the last byte's handshake, busy_o=0 and hex_ready_o=1 on the next cycle. There is a minimum one idle cycle between frames.
- Input changes while busy are ignored. hex_valid_i held high is accepted on the first IDLE cycle.

Optional Feature:
- Macro: HEX2ASCII_STREAM_PREFIX_EN.
- Defined: every frame begins with "0x" (0x30, 0x78) before the digits. This holds regardless of lzs_i and lower_i. Frame length grows by 2.
- Undefined: PREFIX states and logic are absent; the first byte is the first digit.

Test Plan:
- NUM_DIGITS=4, TERM_MODE=2, word 0x1A3F, lower_i=0, lzs_i=0, ascii_ready_i=1 -> bytes 0x31 0x41 0x33 0x46 0x0D 0x0A on consecutive cycles starting 1 cycle after accept; last asserted only on 0x0A.
- Word 0x00B2, lzs_i=1, lower_i=1 -> bytes 0x62 0x32 0x0D 0x0A. Word 0x0000, lzs_i=1 -> 0x30 0x0D 0x0A.
- Word 0xFFFF, ascii_ready_i toggled 1,0,0,1,... -> each byte held stable while stalled; exactly 6 bytes, all 0x46 then CR LF; no drops or duplicates.
- hex_valid_i held high with words 0x1234 then 0x5678 -> second word accepted only after the first frame's 0x0A handshake plus one cycle; hex_ready_o=0 throughout the first frame.
- rst_ni pulsed low after the second digit of 0xABCD -> ascii_valid_o=0 and busy_o=0 immediately; hex_ready_o=1 after release; no residual bytes.
- With HEX2ASCII_STREAM_PREFIX_EN, TERM_MODE=1, NUM_DIGITS=2, word 0x7E -> bytes 0x30 0x78 0x37 0x45 0x20.

Source files
------------

// File: rtl/hex2ascii_stream.sv
// Hex word to ASCII character stream, MSB nibble first, valid/ready on both sides.
// Optional "0x" prefix when HEX2ASCII_STREAM_PREFIX_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a word, hex_ready_o high
// PREFIX0 | presenting '0' of the "0x" prefix (macro only)
// PREFIX1 | presenting 'x' of the "0x" prefix (macro only)
// DIGIT   | presenting the nibble selected by cnt_q
// TERM0   | presenting space or CR
// TERM1   | presenting LF (TERM_MODE=2 only)
module hex2ascii_stream #(
  parameter int NUM_DIGITS = 4,
  parameter int TERM_MODE  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    hex_valid_i,
  output logic                    hex_ready_o,
  input  logic [NUM_DIGITS*4-1:0] hex_data_i,
  input  logic                    lower_i,
  input  logic                    lzs_i,
  output logic                    busy_o,
  output logic                    ascii_valid_o,
  input  logic                    ascii_ready_i,
  output logic [7:0]              ascii_data_o,
  output logic                    ascii_last_o
);

  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_DIGITS - 1);

`ifdef HEX2ASCII_STREAM_PREFIX_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFIX0 = 3'd1,
    PREFIX1 = 3'd2,
    DIGIT   = 3'd3,
    TERM0   = 3'd4,
    TERM1   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIGIT = 3'd3,
    TERM0 = 3'd4,
    TERM1 = 3'd5
  } state_t;
`endif

  state_t                  state_q, state_d;
  logic [NUM_DIGITS*4-1:0] word_q, word_d;
  logic                    lower_q, lower_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           lead;
  logic [3:0]              nib;
  logic                    out_hs;

  // Index of the most significant nonzero nibble; all-zero words land on the last digit.
  always_comb begin
    lead = CNT_LAST;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (hex_data_i[(NUM_DIGITS-1-i)*4 +: 4] != 4'h0) lead = CW'(i);
    end
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_q == CW'(NUM_DIGITS - 1 - i)) nib = word_q[i*4 +: 4];
    end
  end

  assign out_hs        = ascii_valid_o & ascii_ready_i;
  assign hex_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign ascii_valid_o = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lower_d = lower_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hex_valid_i) begin
          word_d  = hex_data_i;
          lower_d = lower_i;
          cnt_d   = lzs_i ? lead : '0;
`ifdef HEX2ASCII_STREAM_PREFIX_EN
          state_d = PREFIX0;
`else
          state_d = DIGIT;
`endif
        end
      end
`ifdef HEX2ASCII_STREAM_PREFIX_EN
      PREFIX0: if (out_hs) state_d = PREFIX1;
      PREFIX1: if (out_hs) state_d = DIGIT;
`endif
      DIGIT: begin
        if (out_hs) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = (TERM_MODE == 0) ? IDLE : TERM0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      TERM0: if (out_hs) state_d = (TERM_MODE == 2) ? TERM1 : IDLE;
      TERM1: if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      lower_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lower_q <= lower_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output byte is a pure function of registered state, so it holds while stalled.
  always_comb begin
    ascii_data_o = 8'h00;
    ascii_last_o = 1'b0;
    case (state_q)
`ifdef HEX2ASCII_STREAM_PREFIX_EN
      PREFIX0: ascii_data_o = 8'h30;
      PREFIX1: ascii_data_o = 8'h78;
`endif
      DIGIT: begin
        if (nib < 4'd10) ascii_data_o = 8'h30 + {4'h0, nib};
        else             ascii_data_o = (lower_q ? 8'h57 : 8'h37) + {4'h0, nib};
        ascii_last_o = (TERM_MODE == 0) && (cnt_q == CNT_LAST);
      end
      TERM0: begin
        ascii_data_o = (TERM_MODE == 2) ? 8'h0D : 8'h20;
        ascii_last_o = (TERM_MODE == 1);
      end
      TERM1: begin
        ascii_data_o = 8'h0A;
        ascii_last_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex2ascii_stream.sv
// Directed bench for hex2ascii_stream: 4-digit CR LF instance plus a 2-digit space instance.
// Expected frames include "0x" when HEX2ASCII_STREAM_PREFIX_EN is defined.
module tb_hex2ascii_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        hex_valid_i, hex_ready_o, lower_i, lzs_i, busy_o;
  logic [15:0] hex_data_i;
  logic        ascii_valid_o, ascii_ready_i, ascii_last_o;
  logic [7:0]  ascii_data_o;

  logic        h2_valid, h2_ready, h2_busy, a2_valid, a2_last;
  logic [7:0]  h2_data, a2_data;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] q2[$];

  always #5 clk_i = ~clk_i;

  hex2ascii_stream #(.NUM_DIGITS(4), .TERM_MODE(2)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hex_valid_i(hex_valid_i), .hex_ready_o(hex_ready_o), .hex_data_i(hex_data_i),
    .lower_i(lower_i), .lzs_i(lzs_i), .busy_o(busy_o),
    .ascii_valid_o(ascii_valid_o), .ascii_ready_i(ascii_ready_i),
    .ascii_data_o(ascii_data_o), .ascii_last_o(ascii_last_o)
  );

  hex2ascii_stream #(.NUM_DIGITS(2), .TERM_MODE(1)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hex_valid_i(h2_valid), .hex_ready_o(h2_ready), .hex_data_i(h2_data),
    .lower_i(1'b0), .lzs_i(1'b0), .busy_o(h2_busy),
    .ascii_valid_o(a2_valid), .ascii_ready_i(1'b1),
    .ascii_data_o(a2_data), .ascii_last_o(a2_last)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pfx();
`ifdef HEX2ASCII_STREAM_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
  endtask

  task automatic push_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at a negedge; leaves the bench at the negedge after the accepting posedge.
  task automatic accept(input logic [15:0] w, input logic lo, input logic lz, input bit hold);
    int n = 0;
    hex_data_i  = w;
    lower_i     = lo;
    lzs_i       = lz;
    hex_valid_i = 1'b1;
    while (!hex_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_val("accept_ready", hex_ready_o, 1'b1);
    @(negedge clk_i);
    if (!hold) begin
      hex_valid_i = 1'b0;
      hex_data_i  = ~w;
      lower_i     = ~lo;
      lzs_i       = ~lz;
    end
  endtask

  // Takes n handshakes against exp_q; mode 1 drives ready with the pattern 1,0,0,1.
  task automatic collect(input int n, input int mode);
    int idx = 0;
    int k = 0;
    int budget = 0;
    bit stalled = 1'b0;
    logic [8:0] held = '0;
    logic [3:0] pat = 4'b1001;
    check_val("first_latency", ascii_valid_o, 1'b1);
    while (idx < n && budget < 200) begin
      if (stalled)
        check_val("stall_hold", {ascii_valid_o, ascii_last_o, ascii_data_o}, {1'b1, held});
      check_val("valid", ascii_valid_o, 1'b1);
      check_val("busy", busy_o, 1'b1);
      check_val("ready_low", hex_ready_o, 1'b0);
      ascii_ready_i = (mode == 0) ? 1'b1 : pat[k % 4];
      k++;
      if (ascii_valid_o && ascii_ready_i) begin
        check_val("byte", ascii_data_o, exp_q[idx]);
        check_val("last", ascii_last_o, (idx == exp_q.size() - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = ascii_valid_o;
        held = {ascii_last_o, ascii_data_o};
      end
      @(negedge clk_i);
      budget++;
    end
    check_val("collect_count", idx, n);
    ascii_ready_i = 1'b1;
  endtask

  task automatic check_idle();
    check_val("idle_ready", hex_ready_o, 1'b1);
    check_val("idle_busy", busy_o, 1'b0);
    check_val("idle_valid", ascii_valid_o, 1'b0);
    check_val("idle_data", ascii_data_o, 8'h00);
    check_val("idle_last", ascii_last_o, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; hex_valid_i = 1'b0; hex_data_i = '0; lower_i = 1'b0; lzs_i = 1'b0;
    ascii_ready_i = 1'b1; h2_valid = 1'b0; h2_data = '0;
    repeat (3) @(negedge clk_i);
    check_idle();
    check_val("rst_d2_valid", a2_valid, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Upper case, no suppression
    exp_q = {}; push_pfx();
    exp_q.push_back(8'h31); exp_q.push_back(8'h41); exp_q.push_back(8'h33); exp_q.push_back(8'h46);
    push_crlf();
    accept(16'h1A3F, 1'b0, 1'b0, 1'b0); collect(exp_q.size(), 0); check_idle();

    // Leading-zero suppression, lower case
    exp_q = {}; push_pfx(); exp_q.push_back(8'h62); exp_q.push_back(8'h32); push_crlf();
    accept(16'h00B2, 1'b1, 1'b1, 1'b0); collect(exp_q.size(), 0); check_idle();

    // All-zero word with suppression still prints one '0'
    exp_q = {}; push_pfx(); exp_q.push_back(8'h30); push_crlf();
    accept(16'h0000, 1'b0, 1'b1, 1'b0); collect(exp_q.size(), 0); check_idle();

    // Lower case without suppression keeps the zero nibble
    exp_q = {}; push_pfx();
    exp_q.push_back(8'h63); exp_q.push_back(8'h30); exp_q.push_back(8'h64); exp_q.push_back(8'h65);
    push_crlf();
    accept(16'hC0DE, 1'b1, 1'b0, 1'b0); collect(exp_q.size(), 0); check_idle();

    // Back-pressure
    exp_q = {}; push_pfx();
    repeat (4) exp_q.push_back(8'h46);
    push_crlf();
    accept(16'hFFFF, 1'b0, 1'b0, 1'b0); collect(exp_q.size(), 1); check_idle();

    // hex_valid_i held high across two words
    exp_q = {}; push_pfx();
    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    push_crlf();
    accept(16'h1234, 1'b0, 1'b0, 1'b1);
    hex_data_i = 16'h5678;
    collect(exp_q.size(), 0);
    check_val("b2b_idle_ready", hex_ready_o, 1'b1);
    check_val("b2b_idle_busy", busy_o, 1'b0);
    @(negedge clk_i);
    hex_valid_i = 1'b0;
    exp_q = {}; push_pfx();
    exp_q.push_back(8'h35); exp_q.push_back(8'h36); exp_q.push_back(8'h37); exp_q.push_back(8'h38);
    push_crlf();
    collect(exp_q.size(), 0); check_idle();

    // Reset in the middle of a frame
    exp_q = {}; push_pfx();
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    push_crlf();
    accept(16'hABCD, 1'b0, 1'b0, 1'b0);
    collect(exp_q.size() - 4, 0);
    check_val("pre_rst_valid", ascii_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_val("rst_valid", ascii_valid_o, 1'b0);
    check_val("rst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_val("rst_ready", hex_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_val("rst_no_residual", ascii_valid_o, 1'b0);
    end

    // Two-digit, space-terminated instance
    q2 = {};
`ifdef HEX2ASCII_STREAM_PREFIX_EN
    q2.push_back(8'h30); q2.push_back(8'h78);
`endif
    q2.push_back(8'h37); q2.push_back(8'h45); q2.push_back(8'h20);
    check_val("d2_ready", h2_ready, 1'b1);
    h2_data = 8'h7E; h2_valid = 1'b1;
    @(negedge clk_i);
    h2_valid = 1'b0; h2_data = 8'h00;
    for (int i = 0; i < q2.size(); i++) begin
      check_val("d2_valid", a2_valid, 1'b1);
      check_val("d2_byte", a2_data, q2[i]);
      check_val("d2_last", a2_last, (i == q2.size() - 1));
      @(negedge clk_i);
    end
    check_val("d2_end_valid", a2_valid, 1'b0);
    check_val("d2_end_busy", h2_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
